// File: rtl/mac_array_seq_if.sv
// Host/array-control bundle for the systolic MAC sequencer.
// master = command/fetch side, slave = sequencer.
interface mac_array_seq_if #(
  parameter int DIM   = 8,
  parameter int CNT_W = 8
);
  localparam int RW = $clog2(DIM);

  logic             start;
  logic [CNT_W-1:0] k_len;
  logic             load_c;
  logic             busy;
  logic             done;
  logic             mac_en;
  logic             mac_wren;
  logic [CNT_W-1:0] k_idx;
  logic [DIM-1:0]   lane_valid;
  logic [RW-1:0]    c_ld_row;
  logic             c_rd_valid;
  logic [RW-1:0]    c_rd_row;

  modport master (
    output start, k_len, load_c,
    input  busy, done, mac_en, mac_wren, k_idx, lane_valid,
           c_ld_row, c_rd_valid, c_rd_row
  );

  modport slave (
    input  start, k_len, load_c,
    output busy, done, mac_en, mac_wren, k_idx, lane_valid,
           c_ld_row, c_rd_valid, c_rd_row
  );
endinterface

// File: rtl/mac_array_seq.sv
// Sequences a DIM x DIM tpumac array through LOAD, skewed COMPUTE, DRAIN and DONE.
// Outputs are decoded from next state/count and registered, so they line up with the state they describe.
module mac_array_seq #(
  parameter int DIM   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_array_seq_if.slave   bus
);
  localparam int RW = $clog2(DIM);
  localparam int CW = CNT_W + 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);
  localparam logic [CW-1:0] SKEW     = CW'(2 * DIM - 3);
  localparam logic [RW-1:0] TOP_ROW  = RW'(DIM - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] k_len_q, k_len_d;
  logic [CW-1:0]    t_last;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_wren_q, mac_wren_d;
  logic [CNT_W-1:0] k_idx_q, k_idx_d;
  logic [DIM-1:0]   lane_valid_q, lane_valid_d;
  logic [RW-1:0]    c_ld_row_q, c_ld_row_d;
  logic             c_rd_valid_q, c_rd_valid_d;
  logic [RW-1:0]    c_rd_row_q, c_rd_row_d;

  // Last COMPUTE step is k_len + 2*DIM - 3; CW bits keep k_len = 255 from wrapping.
  assign t_last = {1'b0, k_len_q} + SKEW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    k_len_d = k_len_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          k_len_d = bus.k_len;
          if (bus.load_c)          state_d = LOAD;
          else if (bus.k_len == 0) state_d = DRAIN;
          else                     state_d = COMPUTE;
        end
      end
      LOAD: begin
        if (cnt_q == LAST_ROW) begin
          state_d = (k_len_q == 0) ? DRAIN : COMPUTE;
          cnt_d   = '0;
        end
      end
      COMPUTE: begin
        if (cnt_q == t_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_ROW) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    mac_en_d     = (state_d == LOAD) || (state_d == COMPUTE) || (state_d == DRAIN);
    mac_wren_d   = (state_d == LOAD) || (state_d == DRAIN);
    k_idx_d      = '0;
    lane_valid_d = '0;
    c_ld_row_d   = '0;
    c_rd_valid_d = (state_d == DRAIN);
    c_rd_row_d   = '0;
    if (state_d == LOAD) begin
      c_ld_row_d = TOP_ROW - cnt_d[RW-1:0];
    end
    if (state_d == COMPUTE) begin
      if (cnt_d < {1'b0, k_len_d}) k_idx_d = cnt_d[CNT_W-1:0];
      // Lane i sees operand (t - i); outside that window the datapath injects zeros.
      for (int i = 0; i < DIM; i++) begin
        lane_valid_d[i] = (cnt_d >= CW'(i)) && (cnt_d < CW'(i) + {1'b0, k_len_d});
      end
    end
    if (state_d == DRAIN) begin
      c_rd_row_d = TOP_ROW - cnt_d[RW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_len_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_wren_q   <= 1'b0;
      k_idx_q      <= '0;
      lane_valid_q <= '0;
      c_ld_row_q   <= '0;
      c_rd_valid_q <= 1'b0;
      c_rd_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_len_q      <= k_len_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mac_en_q     <= mac_en_d;
      mac_wren_q   <= mac_wren_d;
      k_idx_q      <= k_idx_d;
      lane_valid_q <= lane_valid_d;
      c_ld_row_q   <= c_ld_row_d;
      c_rd_valid_q <= c_rd_valid_d;
      c_rd_row_q   <= c_rd_row_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.mac_wren   = mac_wren_q;
  assign bus.k_idx      = k_idx_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.c_ld_row   = c_ld_row_q;
  assign bus.c_rd_valid = c_rd_valid_q;
  assign bus.c_rd_row   = c_rd_row_q;
endmodule
